// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN/HALTED
// control FSM with branch/jump redirect, stall and a sticky halt.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             halt,
  input  logic [31:0]      instruction,
  output logic [31:0]      inst_address,
  output logic [31:0]      ifid_instruction,
  output logic [31:0]      ifid_pc_plus4,
  output logic             ifid_valid,
  output logic             misalign_err,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        ifid_instruction_q;
  logic [31:0]        ifid_pc_plus4_q;
  logic               ifid_valid_q;
  logic               misalign_q;
  logic               halted_q;
  logic [CNT_W-1:0]   fetch_count_q;

  logic               redirect_d;
  logic [31:0]        target_d;
  logic [31:0]        pc_plus4_d;
  logic [CNT_W-1:0]   fetch_count_d;

  // Branch wins over jump when both redirect in the same cycle.
  assign redirect_d    = branch_taken | jump;
  assign target_d      = branch_taken ? branch_target : jump_target;
  assign pc_plus4_d    = pc_q + 32'd4;
  assign fetch_count_d = fetch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q            <= BOOT;
      pc_q               <= RESET_PC_ALIGNED;
      ifid_instruction_q <= 32'h0000_0000;
      ifid_pc_plus4_q    <= 32'h0000_0000;
      ifid_valid_q       <= 1'b0;
      misalign_q         <= 1'b0;
      halted_q           <= 1'b0;
      fetch_count_q      <= '0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
        end
        RUN: begin
          if (halt) begin
            state_q            <= HALTED;
            halted_q           <= 1'b1;
            ifid_instruction_q <= 32'h0000_0000;
            ifid_valid_q       <= 1'b0;
          end else if (redirect_d) begin
            // Redirect squashes the in-flight fetch even while stalled.
            pc_q               <= {target_d[31:2], 2'b00};
            ifid_instruction_q <= 32'h0000_0000;
            ifid_valid_q       <= 1'b0;
            misalign_q         <= |target_d[1:0];
          end else if (!stall) begin
            pc_q               <= pc_plus4_d;
            ifid_instruction_q <= instruction;
            ifid_pc_plus4_q    <= pc_plus4_d;
            ifid_valid_q       <= 1'b1;
            fetch_count_q      <= fetch_count_d;
          end
        end
        HALTED: begin
          ifid_valid_q <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign inst_address     = pc_q;
  assign ifid_instruction = ifid_instruction_q;
  assign ifid_pc_plus4    = ifid_pc_plus4_q;
  assign ifid_valid       = ifid_valid_q;
  assign misalign_err     = misalign_q;
  assign halted           = halted_q;
  assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// stimulus, all compared each cycle against a behavioural fetch-stage model.
module tb_instruction_fetch;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic          jump;
  logic [31:0]   jump_target;
  logic          halt;
  logic [31:0]   instruction;
  logic [31:0]   inst_address;
  logic [31:0]   ifid_instruction;
  logic [31:0]   ifid_pc_plus4;
  logic          ifid_valid;
  logic          misalign_err;
  logic          halted;
  logic [CW-1:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model: phase 0 = boot cycle pending, 1 = running, 2 = halted.
  int            m_phase;
  logic [31:0]   m_pc;
  logic [31:0]   m_instr;
  logic [31:0]   m_pp4;
  logic          m_valid;
  logic          m_mis;
  int unsigned   m_cnt;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .halt             (halt),
    .instruction      (instruction),
    .inst_address     (inst_address),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid),
    .misalign_err     (misalign_err),
    .halted           (halted),
    .fetch_count      (fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h2008_0005;
    else if (a == 32'h4) return 32'h2009_0003;
    else                 return {a[15:0] ^ 16'h1357, a[31:16]} ^ 32'h0BAD_0000;
  endfunction

  assign instruction = mem_word(inst_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    if (!reset_n) begin
      m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0; m_cnt = 0;
    end else begin
      m_mis = 1'b0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (halt) begin
          m_phase = 2; m_instr = 32'h0; m_valid = 1'b0;
        end else if (branch_taken || jump) begin
          tgt     = branch_taken ? branch_target : jump_target;
          m_pc    = tgt & 32'hFFFF_FFFC;
          m_instr = 32'h0;
          m_valid = 1'b0;
          m_mis   = (tgt % 4) != 0;
        end else if (!stall) begin
          m_instr = mem_word(m_pc);
          m_pp4   = m_pc + 32'd4;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
          m_cnt   = (m_cnt + 1) % (1 << CW);
        end
      end
    end
  endtask

  // One transaction: model predicts the edge, then every output is compared.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    chk({tag, ".pc"},    inst_address, m_pc);
    chk({tag, ".instr"}, ifid_instruction, m_instr);
    chk({tag, ".pp4"},   ifid_pc_plus4, m_pp4);
    chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
    chk({tag, ".mis"},   {31'h0, misalign_err}, {31'h0, m_mis});
    chk({tag, ".halt"},  {31'h0, halted}, {31'h0, (m_phase == 2)});
    chk({tag, ".cnt"},   {{(32-CW){1'b0}}, fetch_count}, m_cnt);
    $display("%0t %s rst_n=%0b st=%0b br=%0b j=%0b h=%0b pc=%h ifid=%h pp4=%h v=%0b mis=%0b hl=%0b cnt=%0d",
             $time, tag, reset_n, stall, branch_taken, jump, halt, inst_address,
             ifid_instruction, ifid_pc_plus4, ifid_valid, misalign_err, halted, fetch_count);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  initial begin
    m_phase = 0; m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    reset_n = 1'b0;
    idle_inputs();
    cycle("rst0");
    cycle("rst1");
    chk("lit_rst_valid", {31'h0, ifid_valid}, 32'h0);
    chk("lit_rst_cnt", {{(32-CW){1'b0}}, fetch_count}, 32'h0);
    chk("lit_rst_pc", inst_address, 32'h0);
    chk("lit_rst_halted", {31'h0, halted}, 32'h0);

    reset_n = 1'b1;
    cycle("boot");
    chk("lit_boot_valid", {31'h0, ifid_valid}, 32'h0);
    chk("lit_boot_pc", inst_address, 32'h0);
    cycle("f0");
    chk("lit_f0_instr", ifid_instruction, 32'h2008_0005);
    chk("lit_f0_pp4", ifid_pc_plus4, 32'h4);
    cycle("f1");
    chk("lit_f1_instr", ifid_instruction, 32'h2009_0003);
    chk("lit_f1_pp4", ifid_pc_plus4, 32'h8);
    chk("lit_f1_cnt", {{(32-CW){1'b0}}, fetch_count}, 32'd2);

    stall = 1'b1;
    repeat (3) cycle("stall");
    chk("lit_stall_pc", inst_address, 32'h8);
    chk("lit_stall_cnt", {{(32-CW){1'b0}}, fetch_count}, 32'd2);
    chk("lit_stall_instr", ifid_instruction, 32'h2009_0003);
    stall = 1'b0;
    cycle("resume");
    chk("lit_resume_pp4", ifid_pc_plus4, 32'hC);

    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    cycle("br_stall");
    chk("lit_br_pc", inst_address, 32'h40);
    chk("lit_br_valid", {31'h0, ifid_valid}, 32'h0);
    stall = 1'b0; jump = 1'b1; jump_target = 32'h80; branch_target = 32'h60;
    cycle("br_jmp");
    chk("lit_brj_pc", inst_address, 32'h60);
    branch_taken = 1'b0; jump_target = 32'h46;
    cycle("jmp_mis");
    chk("lit_jmp_pc", inst_address, 32'h44);
    chk("lit_jmp_mis", {31'h0, misalign_err}, 32'h1);
    jump = 1'b0;
    cycle("after_mis");
    chk("lit_mis_clear", {31'h0, misalign_err}, 32'h0);

    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cycle("to_top");
    branch_taken = 1'b0;
    cycle("wrap");
    chk("lit_wrap_pp4", ifid_pc_plus4, 32'h0);
    chk("lit_wrap_pc", inst_address, 32'h0);
    halt = 1'b1;
    cycle("halt");
    chk("lit_halt_h", {31'h0, halted}, 32'h1);
    halt = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    cycle("halt_br");
    chk("lit_halt_pc", inst_address, 32'h0);
    chk("lit_halt_valid", {31'h0, ifid_valid}, 32'h0);
    idle_inputs();

    reset_n = 1'b0;
    cycle("rst2");
    reset_n = 1'b1;
    cycle("boot2");
    repeat (5) cycle("fetch5");
    halt = 1'b1;
    cycle("halt5");
    halt = 1'b0;
    cycle("halted5");
    chk("lit_h5_cnt", {{(32-CW){1'b0}}, fetch_count}, 32'd5);
    reset_n = 1'b0;
    cycle("rst_halted");
    chk("lit_rh_halted", {31'h0, halted}, 32'h0);
    chk("lit_rh_cnt", {{(32-CW){1'b0}}, fetch_count}, 32'h0);
    chk("lit_rh_pp4", ifid_pc_plus4, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      reset_n       = (m_phase == 2) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 79) != 0);
      stall         = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      halt          = ($urandom_range(0, 59) == 0);
      branch_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      jump_target   = $urandom;
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, width of the delivered-instruction counter.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising clock edge.
REQ-005 stall  input  1  hold PC and IF/ID register; no new instruction delivered.
REQ-006 branch_taken  input  1  redirect PC to branch_target.
REQ-007 branch_target  input  32  branch destination byte address.
REQ-008 jump  input  1  redirect PC to jump_target.
REQ-009 jump_target  input  32  jump destination byte address.
REQ-010 halt  input  1  stop fetching; sticky until reset.
REQ-011 instruction  input  32  word returned by instruction memory for inst_address, valid same cycle.
REQ-012 inst_address  output  32  current PC, driven to instruction memory.
REQ-013 ifid_instruction  output  32  registered fetched instruction.
REQ-014 ifid_pc_plus4  output  32  registered PC+4 of the fetched instruction.
REQ-015 ifid_valid  output  1  ifid_instruction holds a real instruction, not a bubble.
REQ-016 misalign_err  output  1  one-cycle pulse: redirect target had nonzero bits [1:0].
REQ-017 halted  output  1  FSM is in HALTED.
REQ-018 fetch_count  output  CNT_W  number of instructions delivered since reset.

Function
REQ-019 FSM states: BOOT, RUN, HALTED; BOOT->RUN unconditionally after one cycle; RUN->HALTED when halt=1; HALTED exits only by reset.
REQ-020 inst_address SHALL equal the PC register combinationally; PC is always word-aligned (bits [1:0]=00).
REQ-021 BOOT: PC held at RESET_PC, ifid_valid=0, no counter update.
REQ-022 RUN per-edge priority: halt > redirect > stall > normal.
REQ-023 Redirect (branch_taken or jump): PC <= target with bits [1:0] cleared; IF/ID loaded as bubble (ifid_valid=0, ifid_instruction=32'h0000_0000); applies even if stall=1.
REQ-024 branch_taken and jump asserted together: branch_target wins.
REQ-025 misalign_err=1 for exactly the cycle after a redirect whose selected target had [1:0]!=00, else 0.
REQ-026 Stall without redirect: PC, ifid_instruction, ifid_pc_plus4, ifid_valid, fetch_count all hold.
REQ-027 Normal: ifid_instruction<=instruction, ifid_pc_plus4<=PC+4, ifid_valid<=1, PC<=PC+4, fetch_count+=1.
REQ-028 PC+4 arithmetic modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_count wraps modulo 2^CNT_W.
REQ-029 halt=1 in RUN: enter HALTED same edge; PC holds; IF/ID loaded as bubble; redirects and stall ignored thereafter.
REQ-030 HALTED: PC, fetch_count hold; ifid_valid=0; halted=1.

Reset
REQ-031 reset_n=0 at an edge, in any state or mid-stall/redirect: state<=BOOT, PC<=RESET_PC, ifid_instruction<=0, ifid_pc_plus4<=0, ifid_valid<=0, misalign_err<=0, fetch_count<=0, halted<=0.
REQ-032 Reset overrides every other input on the same edge.

Verification
REQ-033 Release reset, memory words 0x20080005@0, 0x20090003@4, no stall -> cycle1 BOOT bubble; then ifid_instruction=0x20080005/pc_plus4=4, next 0x20090003/8; fetch_count=2.
REQ-034 stall=1 for 3 cycles at PC=8 -> inst_address stays 8, IF/ID and fetch_count unchanged; resumes at 8 when stall drops.
REQ-035 branch_taken=1, target=0x40, stall=1 same cycle -> next PC=0x40, ifid_valid=0; branch+jump (0x80) together -> PC=0x40.
REQ-036 jump target 0x46 -> PC=0x44, misalign_err high exactly one cycle.
REQ-037 PC=0xFFFF_FFFC normal fetch -> ifid_pc_plus4=0, PC=0; halt=1 then branch_taken=1 -> halted=1, PC frozen, ifid_valid=0.
REQ-038 reset_n=0 while HALTED with fetch_count=5 -> next edge all outputs at reset values, state BOOT.
